multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Parametrised multi-cycle successor to the single-cycle MIPS decoder.
- A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, using a single shared memory port with a mem_ready handshake.
- Adds behaviour the single-cycle decoder lacks: real beq/bne/j control, a memory-wait timeout, and illegal-opcode/funct reporting.
- Drives the multi-cycle datapath: PC, IR, register file, ALU, ALUOut and the memory mux.

Parameters:
- ALU_OP_W, 3, width of alu_op (>=3). Encodings: ADD=0 SUB=1 AND=2 OR=3 SLT=4, zero-extended.
- MEM_TIMEOUT, 15, maximum cycles spent waiting for mem_ready in a memory state. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  IR[31:26], stable after the FETCH IR write
- func  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  load PC
- i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
- ir_write  out  1  load IR
- reg_dst  out  2  write register select: 00=rt, 01=rd, 10=$31
- reg_write  out  1  register file write enable
- mem_to_reg  out  2  writeback data select: 00=ALUOut, 01=MDR, 10=PC
- alu_src_a  out  1  ALU A operand: 0=PC, 1=A register
- alu_src_b  out  2  ALU B operand: 00=B, 01=4, 10=sign-extended imm, 11=sign-extended imm<<2
- alu_op  out  ALU_OP_W  ALU operation
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- pc_src  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  one-cycle pulse on an unsupported opcode or funct
- mem_err  out  1  sticky flag: memory timeout occurred
- state  out  4  current FSM state, for debug

Behaviour:
- Reset is asynchronous: state=FETCH, timeout counter=0, mem_err=0. While rst=1, every control output is forced to 0.
- All outputs are Moore-decoded from state. Exceptions that also depend on inputs: pc_write, ir_write and instr_done (mem_ready or zero), and illegal (opcode/func).
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - On mem_ready: go to DECODE; otherwise stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=ADD (precomputes the branch target).
  - Next state by opcode: 000000->EXEC_R; 001000/001100->EXEC_I; 100011/101011->MEM_ADDR; 000100/000101->BRANCH; 000010->JUMP.
  - Any other opcode: illegal=1, go to FETCH.
- EXEC_R:
  - Outputs: alu_src_a=1, alu_src_b=00.
  - alu_op from func: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT -> R_WB.
  - Unknown func: illegal=1, alu_op=ADD, go to FETCH with no writeback.
- R_WB: reg_dst=01, reg_write=1, mem_to_reg=00, instr_done=1 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10; alu_op=ADD for addi, AND for andi -> I_WB.
- I_WB: reg_dst=00, reg_write=1, instr_done=1 -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD. Next: lw->MEM_RD, sw->MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Waits for mem_ready, then -> MEM_WB.
- MEM_WB: reg_dst=00, reg_write=1, mem_to_reg=01, instr_done=1 -> FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Waits for mem_ready; on ready, instr_done=1 and -> FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01.
  - pc_write = (beq & zero) | (bne & ~zero).
  - instr_done=1 -> FETCH.
- JUMP: pc_src=10, pc_write=1, instr_done=1 -> FETCH.
- Timeout:
  - The counter increments on each cycle spent in FETCH/MEM_RD/MEM_WR without mem_ready, and clears on any state change.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0: set mem_err (sticky until rst) and go to FETCH. No strobe reaches the register file.
  - mem_ready arriving on the same cycle as the limit: the access completes normally and no error is raised.
- rst asserted mid-instruction aborts it immediately; no partial writeback occurs.

Optional Feature:
- Macro: JAL_EN.
- Defined: opcode 000011 decodes to JUMP_LINK, with outputs pc_src=10, pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10, instr_done=1 -> FETCH. PC already holds PC+4.
- Undefined: 000011 is illegal (illegal pulse, return to FETCH). The reg_dst=10 and mem_to_reg=10 codes are never driven.

Test Plan:
- add (op 000000, func 100000), mem_ready=1 in FETCH -> states FETCH, DECODE, EXEC_R, R_WB; alu_op=0, reg_dst=01, reg_write=1, instr_done pulses on cycle 4.
- lw (100011), mem_ready delayed 3 cycles in MEM_RD -> mem_read held high 4 cycles, then MEM_WB with mem_to_reg=01, reg_write=1; mem_err=0.
- beq with zero=1, then bne with zero=1 -> pc_write=1 with pc_src=01 for beq; pc_write=0 for bne.
- opcode 111111, and op 000000 with func 000111 -> illegal pulses once each, no reg_write; FSM back in FETCH.
- sw with mem_ready held 0, MEM_TIMEOUT=15 -> mem_err rises after 15 wait cycles, FSM returns to FETCH, mem_err stays 1 until rst.
- rst pulsed during MEM_WB, and JAL opcode 000011 with/without JAL_EN -> all outputs 0 while rst=1 and state=FETCH after; with JAL_EN: reg_dst=10, mem_to_reg=10, pc_write=1; without it: illegal pulse.

Source files
------------

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Moore control FSM for a multi-cycle MIPS datapath. It sequences fetch,
//   decode, execute, memory and writeback over one shared memory port with a
//   mem_ready handshake. It provides beq/bne/j control, a memory-wait timeout
//   and illegal opcode/funct reporting.
//
// Parameters:
//   ALU_OP_W    width of alu_op (>=3): ADD=0 SUB=1 AND=2 OR=3 SLT=4
//   MEM_TIMEOUT cycles allowed waiting for mem_ready in a memory state (0=off)
//
// Optional feature macro: JAL_EN (opcode 000011 decodes to jump-and-link).
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   opcode, func, zero           IR fields and ALU zero flag
//   mem_ready                    memory completes the current access
//   pc_write, i_or_d, ir_write   PC load, memory address select, IR load
//   reg_dst, reg_write           write register select, regfile write enable
//   mem_to_reg                   writeback data select
//   alu_src_a, alu_src_b, alu_op ALU operand selects and operation
//   mem_read, mem_write          memory strobes
//   pc_src                       PC source select
//   instr_done, illegal          retire pulse, unsupported opcode/funct pulse
//   mem_err                      sticky memory timeout flag
//   state                        current FSM state (debug)
//
// State encoding on the debug port:
//   0 FETCH  1 DECODE  2 EXEC_R  3 R_WB  4 EXEC_I  5 I_WB  6 MEM_ADDR
//   7 MEM_RD 8 MEM_WB  9 MEM_WR 10 BRANCH 11 JUMP 12 JUMP_LINK
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int unsigned ALU_OP_W    = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          opcode,
  input  logic [5:0]          func,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic [1:0]          reg_dst,
  output logic                reg_write,
  output logic [1:0]          mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_read,
  output logic                mem_write,
  output logic [1:0]          pc_src,
  output logic                instr_done,
  output logic                illegal,
  output logic                mem_err,
  output logic [3:0]          state
);

  // The counter only has to hold values up to MEM_TIMEOUT-1.
  localparam int unsigned CNT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam int unsigned CNT_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam bit          TO_EN    = (MEM_TIMEOUT != 0);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef JAL_EN
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(0);
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_AND = ALU_OP_W'(2);
  localparam logic [ALU_OP_W-1:0] ALU_OR  = ALU_OP_W'(3);
  localparam logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(4);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_R_WB      = 4'd3,
    S_EXEC_I    = 4'd4,
    S_I_WB      = 4'd5,
    S_MEM_ADDR  = 4'd6,
    S_MEM_RD    = 4'd7,
    S_MEM_WB    = 4'd8,
    S_MEM_WR    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JUMP_LINK = 4'd12
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q, mem_err_d;
  logic             mem_wait;

  // A memory state still waiting for the access to complete.
  assign mem_wait = ((state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                     (state_q == S_MEM_WR)) && !mem_ready;

  // State, wait counter and sticky error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    mem_err_d  = mem_err_q;
    pc_write   = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    pc_src     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed in the ALU while the instruction is read.
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OP_RTYPE:        state_d = S_EXEC_R;
          OP_ADDI, OP_ANDI: state_d = S_EXEC_I;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
`ifdef JAL_EN
          OP_JAL:          state_d = S_JUMP_LINK;
`endif
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        state_d   = S_R_WB;
        case (func)
          FN_ADD: alu_op = ALU_ADD;
          FN_SUB: alu_op = ALU_SUB;
          FN_AND: alu_op = ALU_AND;
          FN_OR:  alu_op = ALU_OR;
          FN_SLT: alu_op = ALU_SLT;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_R_WB: begin
        reg_dst    = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'b01;
        pc_write   = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`ifdef JAL_EN
      S_JUMP_LINK: begin
        // PC already holds PC+4, so it is the link value written to $31.
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    // Wait counter: counts unanswered cycles, abandons the access at the limit.
    if (mem_wait && TO_EN) begin
      if (cnt_q == CNT_W'(CNT_LAST)) begin
        mem_err_d = 1'b1;
        state_d   = S_FETCH;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Reset suppresses every control strobe, including mid-instruction.
    if (rst) begin
      pc_write   = 1'b0;
      i_or_d     = 1'b0;
      ir_write   = 1'b0;
      reg_dst    = 2'b00;
      reg_write  = 1'b0;
      mem_to_reg = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = ALU_ADD;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      pc_src     = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

  assign mem_err = mem_err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Cycle-by-cycle vectors for multicycle_controller. Each row gives the
//   inputs for one cycle and the expected state plus input-dependent outputs;
//   the per-state fixed control values come from a hand-written table.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

  localparam logic [3:0] F = 4'd0, D = 4'd1, ER = 4'd2, RW = 4'd3, EI = 4'd4,
                         IW = 4'd5, MA = 4'd6, MR = 4'd7, MWB = 4'd8, MWR = 4'd9,
                         BR = 4'd10, J = 4'd11, JL = 4'd12;

  localparam logic [5:0] OP_R = 6'b000000, OP_ANDI = 6'b001100, OP_LW = 6'b100011,
                         OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_BNE = 6'b000101,
                         OP_J = 6'b000010, OP_JAL = 6'b000011, OP_BAD = 6'b111111;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010,
                         FN_SLT = 6'b101010, FN_BAD = 6'b000111;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, i_or_d, ir_write, reg_write, alu_src_a;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic       mem_read, mem_write, instr_done, illegal, mem_err;
  logic [3:0] state;

  multicycle_controller #(.ALU_OP_W(3), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .reg_dst(reg_dst), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .mem_read(mem_read), .mem_write(mem_write),
    .pc_src(pc_src), .instr_done(instr_done), .illegal(illegal),
    .mem_err(mem_err), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write;
    logic       i_or_d;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] pc_src;
    logic       instr_done;
    logic       illegal;
    logic       mem_err;
    logic [3:0] state;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic [5:0] fn;
    logic       zero;
    logic       rdy;
    logic [3:0] st;
    logic       pcw;
    logic       irw;
    logic       done;
    logic       ill;
    logic [2:0] aop;
    logic       merr;
  } vec_t;

  vec_t tbl[$];
  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(logic r, logic [5:0] op, logic [5:0] fn, logic z,
                             logic rdy, logic [3:0] st, logic pcw, logic irw,
                             logic done, logic ill, logic [2:0] aop, logic merr);
    vec_t x;
    x.rst = r; x.op = op; x.fn = fn; x.zero = z; x.rdy = rdy; x.st = st;
    x.pcw = pcw; x.irw = irw; x.done = done; x.ill = ill; x.aop = aop; x.merr = merr;
    return x;
  endfunction

  function automatic void p(logic r, logic [5:0] op, logic [5:0] fn, logic z,
                            logic rdy, logic [3:0] st, logic pcw, logic irw,
                            logic done, logic ill, logic [2:0] aop, logic merr);
    tbl.push_back(v(r, op, fn, z, rdy, st, pcw, irw, done, ill, aop, merr));
  endfunction

  // Expected outputs: fixed per-state controls plus the row's dynamic fields.
  function automatic obs_t expect_of(input vec_t r);
    obs_t o;
    o = '0;
    if (r.rst) return o;
    case (r.st)
      F:   begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; end
      D:   o.alu_src_b = 2'b11;
      ER:  o.alu_src_a = 1'b1;
      RW:  begin o.reg_dst = 2'b01; o.reg_write = 1'b1; end
      EI:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      IW:  o.reg_write = 1'b1;
      MA:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
      MR:  begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
      MWB: begin o.reg_write = 1'b1; o.mem_to_reg = 2'b01; end
      MWR: begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
      BR:  begin o.alu_src_a = 1'b1; o.pc_src = 2'b01; end
      J:   o.pc_src = 2'b10;
      JL:  begin o.pc_src = 2'b10; o.reg_write = 1'b1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; end
      default: ;
    endcase
    o.state      = r.st;
    o.pc_write   = r.pcw;
    o.ir_write   = r.irw;
    o.instr_done = r.done;
    o.illegal    = r.ill;
    o.alu_op     = r.aop;
    o.mem_err    = r.merr;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.pc_write = pc_write; o.i_or_d = i_or_d; o.ir_write = ir_write;
    o.reg_dst = reg_dst; o.reg_write = reg_write; o.mem_to_reg = mem_to_reg;
    o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b; o.alu_op = alu_op;
    o.mem_read = mem_read; o.mem_write = mem_write; o.pc_src = pc_src;
    o.instr_done = instr_done; o.illegal = illegal; o.mem_err = mem_err;
    o.state = state;
    return o;
  endfunction

  // Drive one cycle after the edge, compare at the falling edge.
  task automatic run_row(input vec_t r, input string name, input int idx);
    obs_t g, e;
    @(posedge clk);
    #1;
    rst = r.rst; opcode = r.op; func = r.fn; zero = r.zero; mem_ready = r.rdy;
    sb.push_back(expect_of(r));
    @(negedge clk);
    g = sample();
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s[%0d] scoreboard empty", name, idx);
    end else begin
      e = sb.pop_front();
      if (g !== e) begin
        errors++;
        $display("FAIL %s[%0d] got=%h (state %0d) expected=%h (state %0d)",
                 name, idx, g, g.state, e, e.state);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // rst op fn z rdy state pcw irw done ill aop merr
    p(1, OP_R, FN_ADD, 0, 0, F, 0, 0, 0, 0, 0, 0);
    // add
    p(0, OP_R, FN_ADD, 0, 1, F,  1, 1, 0, 0, 0, 0);
    p(0, OP_R, FN_ADD, 0, 0, D,  0, 0, 0, 0, 0, 0);
    p(0, OP_R, FN_ADD, 0, 0, ER, 0, 0, 0, 0, 0, 0);
    p(0, OP_R, FN_ADD, 0, 0, RW, 0, 0, 1, 0, 0, 0);
    // sub, slt
    p(0, OP_R, FN_SUB, 0, 1, F,  1, 1, 0, 0, 0, 0);
    p(0, OP_R, FN_SUB, 0, 0, D,  0, 0, 0, 0, 0, 0);
    p(0, OP_R, FN_SUB, 0, 0, ER, 0, 0, 0, 0, 1, 0);
    p(0, OP_R, FN_SUB, 0, 0, RW, 0, 0, 1, 0, 0, 0);
    p(0, OP_R, FN_SLT, 0, 1, F,  1, 1, 0, 0, 0, 0);
    p(0, OP_R, FN_SLT, 0, 0, D,  0, 0, 0, 0, 0, 0);
    p(0, OP_R, FN_SLT, 0, 0, ER, 0, 0, 0, 0, 4, 0);
    p(0, OP_R, FN_SLT, 0, 0, RW, 0, 0, 1, 0, 0, 0);
    // andi
    p(0, OP_ANDI, 0, 0, 1, F,  1, 1, 0, 0, 0, 0);
    p(0, OP_ANDI, 0, 0, 0, D,  0, 0, 0, 0, 0, 0);
    p(0, OP_ANDI, 0, 0, 0, EI, 0, 0, 0, 0, 2, 0);
    p(0, OP_ANDI, 0, 0, 0, IW, 0, 0, 1, 0, 0, 0);
    // lw with three wait cycles
    p(0, OP_LW, 0, 0, 1, F,   1, 1, 0, 0, 0, 0);
    p(0, OP_LW, 0, 0, 0, D,   0, 0, 0, 0, 0, 0);
    p(0, OP_LW, 0, 0, 0, MA,  0, 0, 0, 0, 0, 0);
    p(0, OP_LW, 0, 0, 0, MR,  0, 0, 0, 0, 0, 0);
    p(0, OP_LW, 0, 0, 0, MR,  0, 0, 0, 0, 0, 0);
    p(0, OP_LW, 0, 0, 0, MR,  0, 0, 0, 0, 0, 0);
    p(0, OP_LW, 0, 0, 1, MR,  0, 0, 0, 0, 0, 0);
    p(0, OP_LW, 0, 0, 0, MWB, 0, 0, 1, 0, 0, 0);
    // delayed fetch, then beq taken
    p(0, OP_BEQ, 0, 0, 0, F,  0, 0, 0, 0, 0, 0);
    p(0, OP_BEQ, 0, 0, 0, F,  0, 0, 0, 0, 0, 0);
    p(0, OP_BEQ, 0, 0, 1, F,  1, 1, 0, 0, 0, 0);
    p(0, OP_BEQ, 0, 0, 0, D,  0, 0, 0, 0, 0, 0);
    p(0, OP_BEQ, 0, 1, 0, BR, 1, 0, 1, 0, 1, 0);
    // beq not taken
    p(0, OP_BEQ, 0, 0, 1, F,  1, 1, 0, 0, 0, 0);
    p(0, OP_BEQ, 0, 0, 0, D,  0, 0, 0, 0, 0, 0);
    p(0, OP_BEQ, 0, 0, 0, BR, 0, 0, 1, 0, 1, 0);
    // bne with zero=1 (not taken), then zero=0 (taken)
    p(0, OP_BNE, 0, 1, 1, F,  1, 1, 0, 0, 0, 0);
    p(0, OP_BNE, 0, 1, 0, D,  0, 0, 0, 0, 0, 0);
    p(0, OP_BNE, 0, 1, 0, BR, 0, 0, 1, 0, 1, 0);
    p(0, OP_BNE, 0, 0, 1, F,  1, 1, 0, 0, 0, 0);
    p(0, OP_BNE, 0, 0, 0, D,  0, 0, 0, 0, 0, 0);
    p(0, OP_BNE, 0, 0, 0, BR, 1, 0, 1, 0, 1, 0);
    // j
    p(0, OP_J, 0, 0, 1, F, 1, 1, 0, 0, 0, 0);
    p(0, OP_J, 0, 0, 0, D, 0, 0, 0, 0, 0, 0);
    p(0, OP_J, 0, 0, 0, J, 1, 0, 1, 0, 0, 0);
    // illegal opcode
    p(0, OP_BAD, 0, 0, 1, F, 1, 1, 0, 0, 0, 0);
    p(0, OP_BAD, 0, 0, 0, D, 0, 0, 0, 1, 0, 0);
    p(0, OP_BAD, 0, 0, 0, F, 0, 0, 0, 0, 0, 0);
    // illegal funct
    p(0, OP_R, FN_BAD, 0, 1, F,  1, 1, 0, 0, 0, 0);
    p(0, OP_R, FN_BAD, 0, 0, D,  0, 0, 0, 0, 0, 0);
    p(0, OP_R, FN_BAD, 0, 0, ER, 0, 0, 0, 1, 0, 0);
    p(0, OP_R, FN_BAD, 0, 0, F,  0, 0, 0, 0, 0, 0);
    // jal
    p(0, OP_JAL, 0, 0, 1, F, 1, 1, 0, 0, 0, 0);
`ifdef JAL_EN
    p(0, OP_JAL, 0, 0, 0, D,  0, 0, 0, 0, 0, 0);
    p(0, OP_JAL, 0, 0, 0, JL, 1, 0, 1, 0, 0, 0);
`else
    p(0, OP_JAL, 0, 0, 0, D,  0, 0, 0, 1, 0, 0);
`endif
    p(0, OP_JAL, 0, 0, 0, F, 0, 0, 0, 0, 0, 0);
    // reset during MEM_WB aborts the writeback
    p(0, OP_LW, 0, 0, 1, F,  1, 1, 0, 0, 0, 0);
    p(0, OP_LW, 0, 0, 0, D,  0, 0, 0, 0, 0, 0);
    p(0, OP_LW, 0, 0, 0, MA, 0, 0, 0, 0, 0, 0);
    p(0, OP_LW, 0, 0, 1, MR, 0, 0, 0, 0, 0, 0);
    p(1, OP_LW, 0, 0, 1, F,  0, 0, 0, 0, 0, 0);
    p(0, OP_LW, 0, 0, 0, F,  0, 0, 0, 0, 0, 0);

    foreach (tbl[i]) run_row(tbl[i], "tbl", i);

    // sw: mem_ready on the 15th wait cycle still completes without error
    run_row(v(0, OP_SW, 0, 0, 1, F,  1, 1, 0, 0, 0, 0), "sw_lim_fetch", 0);
    run_row(v(0, OP_SW, 0, 0, 0, D,  0, 0, 0, 0, 0, 0), "sw_lim_dec", 0);
    run_row(v(0, OP_SW, 0, 0, 0, MA, 0, 0, 0, 0, 0, 0), "sw_lim_addr", 0);
    for (int i = 0; i < 14; i++)
      run_row(v(0, OP_SW, 0, 0, 0, MWR, 0, 0, 0, 0, 0, 0), "sw_lim_wait", i);
    run_row(v(0, OP_SW, 0, 0, 1, MWR, 0, 0, 1, 0, 0, 0), "sw_lim_done", 0);
    run_row(v(0, OP_SW, 0, 0, 0, F,   0, 0, 0, 0, 0, 0), "sw_lim_back", 0);

    // sw: mem_ready never comes, timeout after 15 wait cycles
    run_row(v(0, OP_SW, 0, 0, 1, F,  1, 1, 0, 0, 0, 0), "sw_to_fetch", 0);
    run_row(v(0, OP_SW, 0, 0, 0, D,  0, 0, 0, 0, 0, 0), "sw_to_dec", 0);
    run_row(v(0, OP_SW, 0, 0, 0, MA, 0, 0, 0, 0, 0, 0), "sw_to_addr", 0);
    for (int i = 0; i < 15; i++)
      run_row(v(0, OP_SW, 0, 0, 0, MWR, 0, 0, 0, 0, 0, 0), "sw_to_wait", i);
    run_row(v(0, OP_SW, 0, 0, 0, F, 0, 0, 0, 0, 0, 1), "sw_to_err", 0);

    // mem_err is sticky across later instructions
    run_row(v(0, OP_J, 0, 0, 1, F, 1, 1, 0, 0, 0, 1), "sticky", 0);
    run_row(v(0, OP_J, 0, 0, 0, D, 0, 0, 0, 0, 0, 1), "sticky", 1);
    run_row(v(0, OP_J, 0, 0, 0, J, 1, 0, 1, 0, 0, 1), "sticky", 2);
    run_row(v(0, OP_J, 0, 0, 0, F, 0, 0, 0, 0, 0, 1), "sticky", 3);

    // reset clears mem_err; then a fetch that times out also raises it
    run_row(v(1, OP_R, 0, 0, 0, F, 0, 0, 0, 0, 0, 0), "rst_clr", 0);
    for (int i = 0; i < 15; i++)
      run_row(v(0, OP_R, 0, 0, 0, F, 0, 0, 0, 0, 0, 0), "fetch_wait", i);
    run_row(v(0, OP_R, 0, 0, 0, F, 0, 0, 0, 0, 0, 1), "fetch_to_err", 0);
    run_row(v(1, OP_R, 0, 0, 0, F, 0, 0, 0, 0, 0, 0), "rst_end", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
